// File: rtl/apb_initiator_if.sv
// apb_initiator_if
//   Groups the client command/response handshake and the APB bus of a
//   single-channel APB initiator.
//   master : the initiator side (drives cmd_ready, rsp_*, paddr/psel0/penable/
//            pwrite/pwdata/pstrobe; samples cmd_*, prdata/pready/pslaverr)
//   slave  : the environment side (client + APB responder), mirror image
interface apb_initiator_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // client command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strobe;

    // client response (one-cycle pulse, no backpressure)
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    // APB
    logic [ADDR_W-1:0] paddr;
    logic              psel0;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrobe;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslaverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strobe,
        input  prdata, pready, pslaverr,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output paddr, psel0, penable, pwrite, pwdata, pstrobe
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strobe,
        output prdata, pready, pslaverr,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  paddr, psel0, penable, pwrite, pwdata, pstrobe
    );
endinterface

// File: rtl/apb_initiator.sv
// apb_initiator
//   Turns one-at-a-time client commands into APB SETUP/ACCESS transfers and
//   returns read data / error status as a one-cycle response pulse. An ACCESS
//   phase that sees pready low for TIMEOUT consecutive cycles is aborted and
//   reported as a timeout (TIMEOUT = 0 waits forever).
// Ports
//   pclk : bus clock, all state on the rising edge
//   prst : asynchronous active-high reset
//   bus  : apb_initiator_if.master (command, response and APB signals)
module apb_initiator #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            pclk,
    input  logic            prst,
    apb_initiator_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strobe;
    } req_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              timeout;
    } rsp_t;

    state_t           state, state_nxt;
    req_t             req_q;
    rsp_t             rsp_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             accept, done, abort, timeout_hit;

    // wait_cnt holds the number of stalled ACCESS cycles before this one, so
    // the abort fires on the TIMEOUT-th stalled cycle itself.
    assign cnt_inc     = {1'b0, wait_cnt} + (CNT_W+1)'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == (CNT_W+1)'(TIMEOUT));

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) state <= IDLE;
        else      state <= state_nxt;
    end

    // pready/pslaverr only matter in ACCESS; an early pready in SETUP is
    // ignored so the transfer always has a full ACCESS phase. pready is
    // tested before the timeout so a completion on the last allowed cycle wins.
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        done          = 1'b0;
        abort         = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.psel0     = 1'b0;
        bus.penable   = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = !prst;
                if (bus.cmd_valid && !prst) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                bus.psel0 = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                bus.psel0   = 1'b1;
                bus.penable = 1'b1;
                if (bus.pready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Saturating stall counter, cleared in SETUP for each new transfer.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !bus.pready && wait_cnt != '1) begin
            wait_cnt <= cnt_inc[CNT_W-1:0];
        end
    end

    // Request is captured once at accept and held through ACCESS. Reads put
    // zero on pwdata/pstrobe so the responder never sees stale write lanes.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            req_q <= '0;
        end else if (accept) begin
            req_q.write  <= bus.cmd_write;
            req_q.addr   <= bus.cmd_addr;
            req_q.wdata  <= bus.cmd_write ? bus.cmd_wdata  : '0;
            req_q.strobe <= bus.cmd_write ? bus.cmd_strobe : '0;
        end
    end

    // Response fields hold until the next completion; only valid pulses.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            rsp_q <= '0;
        end else begin
            rsp_q.valid <= done || abort;
            if (done) begin
                rsp_q.rdata   <= req_q.write ? '0 : bus.prdata;
                rsp_q.err     <= bus.pslaverr;
                rsp_q.timeout <= 1'b0;
            end else if (abort) begin
                rsp_q.rdata   <= '0;
                rsp_q.err     <= 1'b1;
                rsp_q.timeout <= 1'b1;
            end
        end
    end

    assign bus.paddr       = req_q.addr;
    assign bus.pwrite      = req_q.write;
    assign bus.pwdata      = req_q.wdata;
    assign bus.pstrobe     = req_q.strobe;
    assign bus.rsp_valid   = rsp_q.valid;
    assign bus.rsp_rdata   = rsp_q.rdata;
    assign bus.rsp_err     = rsp_q.err;
    assign bus.rsp_timeout = rsp_q.timeout;
endmodule

// File: tb/tb_apb_initiator.sv
// tb_apb_initiator
//   Bench for apb_initiator: a word-addressed APB responder with programmable
//   wait states / hang / early-pready, a transaction-level expectation model
//   checked every cycle, and directed commands with literal expected results.
module tb_apb_initiator;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic pclk = 1'b0;
    logic prst = 1'b1;
    always #5 pclk = ~pclk;

    apb_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

    apb_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk (pclk),
        .prst (prst),
        .bus  (bif)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- responder ----------------
    logic [31:0] slv_mem [0:63];
    int          wait_cfg  = 0;
    logic        hang_cfg  = 1'b0;
    logic        early_cfg = 1'b0;
    int          acnt = 0;
    logic        mis, acc_ph;

    assign mis          = bif.paddr[1:0] != 2'b00;
    assign acc_ph       = bif.psel0 && bif.penable;
    assign bif.pready   = hang_cfg ? 1'b0 :
                          acc_ph   ? (acnt >= wait_cfg) : (bif.psel0 && early_cfg);
    assign bif.pslaverr = bif.pready && mis;
    assign bif.prdata   = mis ? 32'hBAD0_0BAD : slv_mem[bif.paddr[7:2]];

    always @(posedge pclk) begin
        if (acc_ph && !bif.pready) acnt <= acnt + 1;
        else                       acnt <= 0;
        if (acc_ph && bif.pready && bif.pwrite && !mis)
            for (int b = 0; b < 4; b++)
                if (bif.pstrobe[b]) slv_mem[bif.paddr[7:2]][8*b +: 8] <= bif.pwdata[8*b +: 8];
    end

    // ---------------- expectation model ----------------
    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    logic [31:0] ref_mem [0:63];
    logic        m_busy = 1'b0;
    int          m_acc, m_len;
    logic        m_w, m_err, m_to;
    logic [31:0] m_a, m_d, m_rd;
    logic [3:0]  m_s;
    logic [31:0] last_rd  = '0;
    logic        last_err = 1'b0;
    logic        last_to  = 1'b0;
    int          rsp_cnt  = 0;
    int          acc_cnt  = 0;
    logic [3:0]  seen_strb = '0;

    // A command accepted at edge A occupies SETUP in the cycle after A, then
    // m_len ACCESS cycles, then the response cycle.
    always @(negedge pclk) begin
        logic e_sel, e_en, e_rv, e_rdy;
        int   k;
        if (prst) begin
            m_busy = 1'b0; last_rd = '0; last_err = 1'b0; last_to = 1'b0;
            chk("rst_cmd_ready", bif.cmd_ready, 0);
            chk("rst_psel0", bif.psel0, 0);
            chk("rst_penable", bif.penable, 0);
            chk("rst_pwrite", bif.pwrite, 0);
            chk("rst_paddr", bif.paddr, 0);
            chk("rst_pwdata", bif.pwdata, 0);
            chk("rst_pstrobe", bif.pstrobe, 0);
            chk("rst_rsp_valid", bif.rsp_valid, 0);
            chk("rst_rsp_rdata", bif.rsp_rdata, 0);
            chk("rst_rsp_err", bif.rsp_err, 0);
            chk("rst_rsp_timeout", bif.rsp_timeout, 0);
        end else begin
            e_sel = 1'b0; e_en = 1'b0; e_rv = 1'b0; e_rdy = 1'b1;
            if (m_busy) begin
                k = cyc - m_acc;
                if (k == 0) begin
                    e_sel = 1'b1; e_rdy = 1'b0;
                end else if (k <= m_len) begin
                    e_sel = 1'b1; e_en = 1'b1; e_rdy = 1'b0;
                end else begin
                    e_rv = 1'b1; m_busy = 1'b0;
                    last_rd = m_rd; last_err = m_err; last_to = m_to;
                end
            end
            chk("cmd_ready", bif.cmd_ready, e_rdy);
            chk("psel0", bif.psel0, e_sel);
            chk("penable", bif.penable, e_en);
            chk("rsp_valid", bif.rsp_valid, e_rv);
            chk("rsp_rdata", bif.rsp_rdata, last_rd);
            chk("rsp_err", bif.rsp_err, last_err);
            chk("rsp_timeout", bif.rsp_timeout, last_to);
            if (e_sel) begin
                chk("paddr", bif.paddr, m_a);
                chk("pwrite", bif.pwrite, m_w);
                chk("pwdata", bif.pwdata, m_w ? m_d : 32'h0);
                chk("pstrobe", bif.pstrobe, m_w ? m_s : 4'h0);
            end
            if (bif.rsp_valid) rsp_cnt++;
            if (bif.psel0 && bif.penable) acc_cnt++;
            if (bif.psel0) seen_strb |= bif.pstrobe;
            if (e_rdy && bif.cmd_valid) begin
                m_busy = 1'b1; m_acc = cyc + 1;
                m_w = bif.cmd_write; m_a = bif.cmd_addr; m_d = bif.cmd_wdata; m_s = bif.cmd_strobe;
                if (!hang_cfg && wait_cfg + 1 <= TO) begin
                    m_len = wait_cfg + 1; m_to = 1'b0; m_err = (m_a[1:0] != 2'b00);
                    if (m_w) begin
                        m_rd = '0;
                        if (!m_err)
                            for (int b = 0; b < 4; b++)
                                if (m_s[b]) ref_mem[m_a[7:2]][8*b +: 8] = m_d[8*b +: 8];
                    end else begin
                        m_rd = m_err ? 32'hBAD0_0BAD : ref_mem[m_a[7:2]];
                    end
                end else begin
                    m_len = TO; m_to = 1'b1; m_err = 1'b1; m_rd = '0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int waits, input logic hang, input logic early);
        int n;
        @(posedge pclk); #1;
        wait_cfg = waits; hang_cfg = hang; early_cfg = early;
        acc_cnt = 0; seen_strb = '0;
        bif.cmd_valid = 1'b1; bif.cmd_write = w; bif.cmd_addr = a;
        bif.cmd_wdata = d; bif.cmd_strobe = s;
        n = 0;
        do begin @(negedge pclk); n++; end while (!bif.cmd_ready && n < 50);
        chk("accept_in_time", n < 50, 1);
        @(posedge pclk); #1;
        bif.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic e, output logic t);
        int n;
        n = 0;
        do begin @(negedge pclk); n++; end while (!bif.rsp_valid && n < 100);
        chk("rsp_in_time", n < 100, 1);
        rd = bif.rsp_rdata; e = bif.rsp_err; t = bif.rsp_timeout;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e, t;
        int          n, rsp0;
        int          acc_t [0:9];

        for (int i = 0; i < 64; i++) begin slv_mem[i] = '0; ref_mem[i] = '0; end
        bif.cmd_valid = 1'b0; bif.cmd_write = 1'b0; bif.cmd_addr = '0;
        bif.cmd_wdata = '0; bif.cmd_strobe = '0;

        prst = 1'b1;
        repeat (3) @(posedge pclk);
        #1 prst = 1'b0;
        @(negedge pclk);
        chk("ready_after_reset", bif.cmd_ready, 1);

        // full-word write, zero wait
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 1'b0);
        wait_rsp(rd, e, t);
        chk("wr_err", e, 0); chk("wr_rdata", rd, 0); chk("wr_access_cycles", acc_cnt, 1);

        // read back; strobes must be zero on the bus
        issue(1'b0, 32'h10, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 1'b0);
        wait_rsp(rd, e, t);
        chk("rd_data", rd, 32'hDEAD_BEEF); chk("rd_err", e, 0); chk("rd_pstrobe_zero", seen_strb, 0);

        // partial-strobe write then read
        issue(1'b1, 32'h10, 32'h1234_5678, 4'b0011, 0, 1'b0, 1'b0);
        wait_rsp(rd, e, t);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, 1'b0);
        wait_rsp(rd, e, t);
        chk("partial_rd_data", rd, 32'hDEAD_5678);

        // misaligned read -> slave error
        issue(1'b0, 32'h13, 32'h0, 4'h0, 0, 1'b0, 1'b0);
        wait_rsp(rd, e, t);
        chk("mis_err", e, 1); chk("mis_timeout", t, 0); chk("mis_rdata", rd, 32'hBAD0_0BAD);

        // three wait states
        issue(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 3, 1'b0, 1'b0);
        wait_rsp(rd, e, t);
        chk("wait3_access_cycles", acc_cnt, 4); chk("wait3_err", e, 0);

        // responder hangs -> timeout after 16 ACCESS cycles
        issue(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b1, 1'b0);
        wait_rsp(rd, e, t);
        chk("to_access_cycles", acc_cnt, 16); chk("to_err", e, 1);
        chk("to_timeout", t, 1); chk("to_rdata", rd, 0);

        // pready on the 16th ACCESS cycle beats the timeout
        issue(1'b0, 32'h20, 32'h0, 4'h0, 15, 1'b0, 1'b0);
        wait_rsp(rd, e, t);
        chk("edge_access_cycles", acc_cnt, 16); chk("edge_err", e, 0);
        chk("edge_timeout", t, 0); chk("edge_rdata", rd, 32'hCAFE_F00D);

        // pready already high in SETUP must not shorten the transfer
        issue(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 1'b1);
        wait_rsp(rd, e, t);
        chk("early_access_cycles", acc_cnt, 1); chk("early_rdata", rd, 32'hCAFE_F00D);
        early_cfg = 1'b0;

        // ten commands with cmd_valid held continuously
        @(posedge pclk); #1;
        wait_cfg = 0; rsp0 = rsp_cnt;
        bif.cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bif.cmd_write = 1'b1; bif.cmd_addr = 32'h40 + 32'(4 * i);
            bif.cmd_wdata = 32'h0101_0101 * 32'(i + 1); bif.cmd_strobe = 4'hF;
            n = 0;
            do begin @(negedge pclk); n++; end while (!bif.cmd_ready && n < 20);
            chk("b2b_accept_in_time", n < 20, 1);
            acc_t[i] = cyc + 1;
            @(posedge pclk); #1;
        end
        bif.cmd_valid = 1'b0;
        repeat (4) @(negedge pclk);
        chk("b2b_rsp_count", rsp_cnt - rsp0, 10);
        for (int i = 1; i < 10; i++) chk("b2b_spacing", acc_t[i] - acc_t[i-1], 3);
        issue(1'b0, 32'h4C, 32'h0, 4'h0, 0, 1'b0, 1'b0);
        wait_rsp(rd, e, t);
        chk("b2b_readback", rd, 32'h0404_0404);

        // reset asserted mid-cycle during ACCESS: bus drops at once, no response
        issue(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b1, 1'b0);
        repeat (3) @(posedge pclk);
        #3 prst = 1'b1;
        #1;
        chk("async_rst_psel0", bif.psel0, 0);
        chk("async_rst_penable", bif.penable, 0);
        chk("async_rst_paddr", bif.paddr, 0);
        chk("async_rst_cmd_ready", bif.cmd_ready, 0);
        rsp0 = rsp_cnt; hang_cfg = 1'b0;
        repeat (2) @(posedge pclk);
        #1 prst = 1'b0;
        repeat (25) @(negedge pclk);
        chk("no_rsp_after_reset_abort", rsp_cnt - rsp0, 0);
        chk("ready_after_mid_reset", bif.cmd_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
